// File: rtl/calc_delta_pkg.sv
// Shared definitions for the multi-channel shortest-path angle delta engine.
//   state_e : FSM state encodings (3-bit) for calculate_delta_multi
//   DIR_CW / DIR_CCW : direction codes reported on dir_shortest
package calc_delta_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DIFF   = 3'd2,
    ST_SELECT = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/angle_shortest_path.sv
// Combinational shortest-path selector for one channel.
// Ports:
//   cw_i        : registered clockwise distance (tgt - cur, wrapped)
//   ccw_i       : registered counter-clockwise distance (cur - tgt, wrapped)
//   delta_o     : the shorter of the two distances
//   dir_o       : DIR_CW when cw is strictly shorter, else DIR_CCW
//   at_target_o : delta_o within DEADBAND counts
module angle_shortest_path
  import calc_delta_pkg::*;
#(
  parameter int ANGLE_W  = 12,
  parameter int DEADBAND = 8
) (
  input  logic [ANGLE_W-1:0] cw_i,
  input  logic [ANGLE_W-1:0] ccw_i,
  output logic [ANGLE_W-1:0] delta_o,
  output logic               dir_o,
  output logic               at_target_o
);

  localparam logic [ANGLE_W-1:0] DB = ANGLE_W'(DEADBAND);

  logic cw_shorter;

  // Strict compare: a half-rotation tie and a zero delta both resolve to CCW.
  assign cw_shorter  = (cw_i < ccw_i);
  assign delta_o     = cw_shorter ? cw_i : ccw_i;
  assign dir_o       = cw_shorter ? DIR_CW : DIR_CCW;
  assign at_target_o = (delta_o <= DB);

endmodule

// File: rtl/calculate_delta_multi.sv
// Time-multiplexed shortest-path angle delta engine for NUM_CH wheel channels.
// A pass is started from IDLE; inputs are snapshotted on the accepting edge and
// each enabled channel then takes three cycles (CHECK, DIFF, SELECT), each
// disabled channel one (CHECK), followed by a single REPORT cycle.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : request a pass (only honoured in IDLE)
//   ch_enable      : channels to compute in this pass
//   target_angle   : packed targets, channel i at [i*ANGLE_W +: ANGLE_W]
//   current_angle  : packed encoder readings, same packing
//   busy           : pass in progress
//   delta_angle    : per-channel shortest distance
//   dir_shortest   : per-channel direction (0 = CW, 1 = CCW)
//   at_target      : per-channel delta within DEADBAND
//   ch_updated     : one-cycle pulse when a channel's outputs are refreshed
//   calc_updated   : one-cycle pulse when the pass completes
module calculate_delta_multi
  import calc_delta_pkg::*;
#(
  parameter int ANGLE_W  = 12,
  parameter int NUM_CH   = 4,
  parameter int DEADBAND = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH*ANGLE_W-1:0] target_angle,
  input  logic [NUM_CH*ANGLE_W-1:0] current_angle,
  output logic                      busy,
  output logic [NUM_CH*ANGLE_W-1:0] delta_angle,
  output logic [NUM_CH-1:0]         dir_shortest,
  output logic [NUM_CH-1:0]         at_target,
  output logic [NUM_CH-1:0]         ch_updated,
  output logic                      calc_updated
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_CH-1:0]         en_snap_q;
  logic [NUM_CH*ANGLE_W-1:0] tgt_snap_q;
  logic [NUM_CH*ANGLE_W-1:0] cur_snap_q;
  logic [ANGLE_W-1:0]        cw_q, ccw_q;
  logic [NUM_CH*ANGLE_W-1:0] delta_q;
  logic [NUM_CH-1:0]         dir_q;
  logic [NUM_CH-1:0]         at_q;
  logic [NUM_CH-1:0]         ch_upd_q;

  logic [ANGLE_W-1:0]        tgt_sel, cur_sel;
  logic [ANGLE_W-1:0]        sel_delta;
  logic                      sel_dir;
  logic                      sel_at;

  assign tgt_sel = tgt_snap_q[int'(idx_q)*ANGLE_W +: ANGLE_W];
  assign cur_sel = cur_snap_q[int'(idx_q)*ANGLE_W +: ANGLE_W];

  angle_shortest_path #(
    .ANGLE_W  (ANGLE_W),
    .DEADBAND (DEADBAND)
  ) u_sel (
    .cw_i        (cw_q),
    .ccw_i       (ccw_q),
    .delta_o     (sel_delta),
    .dir_o       (sel_dir),
    .at_target_o (sel_at)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end
      end
      ST_CHECK: begin
        if (en_snap_q[idx_q]) begin
          state_d = ST_DIFF;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_REPORT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DIFF: state_d = ST_SELECT;
      ST_SELECT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_CHECK;
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      en_snap_q  <= '0;
      tgt_snap_q <= '0;
      cur_snap_q <= '0;
      cw_q       <= '0;
      ccw_q      <= '0;
      delta_q    <= '0;
      dir_q      <= '0;
      at_q       <= '0;
      ch_upd_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ch_upd_q <= '0;
      if ((state_q == ST_IDLE) && start) begin
        en_snap_q  <= ch_enable;
        tgt_snap_q <= target_angle;
        cur_snap_q <= current_angle;
      end
      // Both wrapped distances are registered so the select stage sees only flops.
      if (state_q == ST_DIFF) begin
        cw_q  <= tgt_sel - cur_sel;
        ccw_q <= cur_sel - tgt_sel;
      end
      if (state_q == ST_SELECT) begin
        delta_q[int'(idx_q)*ANGLE_W +: ANGLE_W] <= sel_delta;
        dir_q[idx_q]                            <= sel_dir;
        at_q[idx_q]                             <= sel_at;
        ch_upd_q[idx_q]                         <= 1'b1;
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign calc_updated = (state_q == ST_REPORT);
  assign delta_angle  = delta_q;
  assign dir_shortest = dir_q;
  assign at_target    = at_q;
  assign ch_updated   = ch_upd_q;

endmodule

// File: tb/tb_calculate_delta_multi.sv
module tb_calculate_delta_multi;

  localparam int AW  = 12;
  localparam int NCH = 4;
  localparam int DB  = 8;
  localparam int MOD = 1 << AW;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [NCH-1:0]    ch_enable;
  logic [NCH*AW-1:0] target_angle;
  logic [NCH*AW-1:0] current_angle;
  logic              busy;
  logic [NCH*AW-1:0] delta_angle;
  logic [NCH-1:0]    dir_shortest;
  logic [NCH-1:0]    at_target;
  logic [NCH-1:0]    ch_updated;
  logic              calc_updated;

  calculate_delta_multi #(.ANGLE_W(AW), .NUM_CH(NCH), .DEADBAND(DB)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .ch_enable     (ch_enable),
    .target_angle  (target_angle),
    .current_angle (current_angle),
    .busy          (busy),
    .delta_angle   (delta_angle),
    .dir_shortest  (dir_shortest),
    .at_target     (at_target),
    .ch_updated    (ch_updated),
    .calc_updated  (calc_updated)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pass is a schedule: channel i finishes 3 edges after all earlier
  // channels have been visited (3 edges if enabled, 1 if not); the report
  // pulse follows the last visit; the pass ends one edge later.
  int m_busy = 0;
  int m_cnt  = 0;
  int m_total = 0;
  int m_upd_edge [NCH];
  int m_en  [NCH];
  int m_tgt [NCH];
  int m_cur [NCH];
  int e_delta [NCH] = '{default: 0};
  int e_dir   [NCH] = '{default: 0};
  int e_at    [NCH] = '{default: 0};
  int e_upd  = 0;
  int e_calc = 0;

  function automatic void shortest(input int t, input int c, output int d, output int dir);
    int fwd, back;
    fwd  = ((t - c) % MOD + MOD) % MOD;
    back = (MOD - fwd) % MOD;
    if (fwd < back) begin d = fwd; dir = 0; end
    else begin d = back; dir = 1; end
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_cnt = 0; e_upd = 0; e_calc = 0;
      for (int i = 0; i < NCH; i++) begin e_delta[i] = 0; e_dir[i] = 0; e_at[i] = 0; end
    end else if (m_busy == 0) begin
      e_upd = 0; e_calc = 0;
      if (start) begin
        int acc;
        acc = 0;
        for (int i = 0; i < NCH; i++) begin
          m_en[i]  = int'(ch_enable[i]);
          m_tgt[i] = int'(target_angle[i*AW +: AW]);
          m_cur[i] = int'(current_angle[i*AW +: AW]);
          acc += (m_en[i] != 0) ? 3 : 1;
          m_upd_edge[i] = acc;
        end
        m_total = acc;
        m_cnt = 0;
        m_busy = 1;
      end
    end else begin
      m_cnt++;
      e_upd = 0; e_calc = 0;
      for (int i = 0; i < NCH; i++) begin
        if (m_en[i] != 0 && m_upd_edge[i] == m_cnt) begin
          int d, dr;
          shortest(m_tgt[i], m_cur[i], d, dr);
          e_delta[i] = d; e_dir[i] = dr; e_at[i] = (d <= DB) ? 1 : 0;
          e_upd = e_upd | (1 << i);
        end
      end
      if (m_cnt == m_total) e_calc = 1;
      if (m_cnt == m_total + 1) m_busy = 0;
    end
  end

  bit cmp_en = 0;
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("busy", int'(busy), m_busy);
      chk("calc_updated", int'(calc_updated), e_calc);
      chk("ch_updated", int'(ch_updated), e_upd);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("delta%0d", i), int'(delta_angle[i*AW +: AW]), e_delta[i]);
        chk($sformatf("dir%0d", i), int'(dir_shortest[i]), e_dir[i]);
        chk($sformatf("at%0d", i), int'(at_target[i]), e_at[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int r_edges;
  int r_mask;
  int r_calcs;
  int r_upd_at [NCH];

  task automatic set_inputs(input int en, input int t0, t1, t2, t3, input int c0, c1, c2, c3);
    ch_enable = NCH'(en);
    target_angle  = {AW'(t3), AW'(t2), AW'(t1), AW'(t0)};
    current_angle = {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
  endtask

  // Pulse start, then count edges until calc_updated is seen.
  task automatic run_pass(input bit disturb);
    int n;
    r_edges = -1; r_mask = 0; r_calcs = 0;
    for (int i = 0; i < NCH; i++) r_upd_at[i] = -1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (disturb) begin
      target_angle = ~target_angle;
      start = 1'b1;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) start = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (ch_updated[i]) begin r_upd_at[i] = n; r_mask |= (1 << i); end
      if (calc_updated) begin r_calcs++; r_edges = n; break; end
    end
    if (r_edges < 0) chk("pass_timeout", n, -1);
    // A second report pulse in the next few cycles would be an error.
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (calc_updated) r_calcs++;
    end
  endtask

  function automatic int dlt(input int i);
    return int'(delta_angle[i*AW +: AW]);
  endfunction

  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    @(negedge clock);
    cmp_en = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_delta", int'(delta_angle), 0);
    chk("rst_flags", int'({dir_shortest, at_target, ch_updated, calc_updated}), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Test 1: basic pass, all channels enabled
    set_inputs(4'hF, 100, 200, 5, 3000, 50, 300, 0, 1000);
    run_pass(0);
    chk("t1_edges", r_edges, 12);
    chk("t1_upd0", r_upd_at[0], 3);
    chk("t1_upd1", r_upd_at[1], 6);
    chk("t1_upd2", r_upd_at[2], 9);
    chk("t1_upd3", r_upd_at[3], 12);
    chk("t1_delta0", dlt(0), 50);
    chk("t1_dir0", int'(dir_shortest[0]), 0);
    chk("t1_at0", int'(at_target[0]), 0);
    chk("t1_delta1", dlt(1), 100);
    chk("t1_dir1", int'(dir_shortest[1]), 1);
    chk("t1_at2", int'(at_target[2]), 1);
    chk("t1_delta3", dlt(3), 2000);
    chk("t1_calcs", r_calcs, 1);

    // Test 2: wrap-around
    set_inputs(4'hF, 0, 10, 4090, 7, 0, 4090, 10, 7);
    run_pass(0);
    chk("t2_delta1", dlt(1), 16);
    chk("t2_dir1", int'(dir_shortest[1]), 0);
    chk("t2_delta2", dlt(2), 16);
    chk("t2_dir2", int'(dir_shortest[2]), 1);

    // Test 3: boundaries
    set_inputs(4'hF, 2048, 500, 108, 109, 0, 500, 100, 100);
    run_pass(0);
    chk("t3_delta0", dlt(0), 2048);
    chk("t3_dir0", int'(dir_shortest[0]), 1);
    chk("t3_delta1", dlt(1), 0);
    chk("t3_dir1", int'(dir_shortest[1]), 1);
    chk("t3_at1", int'(at_target[1]), 1);
    chk("t3_delta2", dlt(2), 8);
    chk("t3_at2", int'(at_target[2]), 1);
    chk("t3_delta3", dlt(3), 9);
    chk("t3_at3", int'(at_target[3]), 0);

    // Test 4: masking
    set_inputs(4'b0101, 30, 1000, 40, 2000, 0, 0, 0, 0);
    run_pass(0);
    chk("t4_edges", r_edges, 8);
    chk("t4_mask", r_mask, 5);
    chk("t4_delta0", dlt(0), 30);
    chk("t4_delta1_kept", dlt(1), 0);
    chk("t4_dir1_kept", int'(dir_shortest[1]), 1);
    chk("t4_delta2", dlt(2), 40);
    chk("t4_delta3_kept", dlt(3), 9);
    set_inputs(0, 1, 1, 1, 1, 0, 0, 0, 0);
    run_pass(0);
    chk("t4_zero_edges", r_edges, 4);
    chk("t4_zero_mask", r_mask, 0);
    chk("t4_zero_calcs", r_calcs, 1);

    // Test 5: snapshot and ignored start while busy
    set_inputs(4'hF, 60, 70, 80, 90, 0, 0, 0, 0);
    run_pass(1);
    chk("t5_edges", r_edges, 12);
    chk("t5_calcs", r_calcs, 1);
    chk("t5_delta0", dlt(0), 60);
    chk("t5_delta3", dlt(3), 90);

    // Test 6: reset during a pass
    set_inputs(4'hF, 300, 400, 500, 600, 0, 0, 0, 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_delta", int'(delta_angle), 0);
    chk("t6_flags", int'({dir_shortest, at_target, ch_updated, calc_updated}), 0);
    @(negedge clock);
    reset_n = 1'b1;
    r_calcs = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (calc_updated) r_calcs++;
    end
    chk("t6_no_calc", r_calcs, 0);
    set_inputs(4'hF, 300, 400, 500, 600, 0, 0, 0, 0);
    run_pass(0);
    chk("t6_edges", r_edges, 12);
    chk("t6_delta0", dlt(0), 300);
    chk("t6_delta3", dlt(3), 600);

    repeat (3) @(negedge clock);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
